// File: rtl/loop_step_player.sv
// Four-step looper: steps a 2-bit index on a programmable grid, picks the chord from static patterns and drives a note gate.
// Optional odd-step swing delay is compiled in with `define LOOP_SWING_EN.
module loop_step_player #(
    parameter int CNT_W = 28
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             loop_en,
    input  logic [CNT_W-1:0] step_period,
    input  logic [CNT_W-1:0] gate_len,
    input  logic [3:0]       pat0,
    input  logic [3:0]       pat1,
    input  logic [3:0]       pat2,
    input  logic [3:0]       pat3,
    output logic             shift_en,
    output logic [1:0]       step,
    output logic [3:0]       track_led,
    output logic [1:0]       chord_sel,
    output logic             note_gate,
    output logic             note_trig
);

`ifdef LOOP_SWING_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_GATE, S_REST, S_SWING} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_GATE, S_REST} state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       step_q, step_d;
    logic [1:0]       chord_q, chord_d;

    logic [CNT_W-1:0] p_new;
    logic             running;
    logic             wrap;
    logic             tick;
    logic             swing_eval;
    logic             defer;
    logic             eval;
    logic [1:0]       eval_step;
    logic [3:0]       hit_vec;
    logic             hit;
    logic [1:0]       first_chord;
    logic             fire;
    logic             start_gate;

    assign p_new   = (step_period == '0) ? CNT_W'(1) : step_period;
    assign running = loop_en && (state_q != S_IDLE);
    assign wrap    = (div_q == period_q - CNT_W'(1));
    // The IDLE->START transition evaluates step 0 itself, so no tick is issued in START.
    assign tick    = running && (state_q != S_START) && wrap;

`ifdef LOOP_SWING_EN
    logic [CNT_W-1:0] swing_len;
    assign swing_len  = p_new >> 2;
    assign swing_eval = running && (state_q == S_SWING) && (cnt_q == '0) && !tick;
    assign defer      = tick && eval_step[0] && (swing_len != '0);
`else
    assign swing_eval = 1'b0;
    assign defer      = 1'b0;
`endif

    // A tick evaluates the step it is about to advance to; a swing release evaluates the current one.
    assign eval      = running && ((state_q == S_START) || tick || swing_eval);
    assign eval_step = tick ? (step_q + 2'd1) : step_q;
    assign hit_vec   = {pat3[eval_step], pat2[eval_step], pat1[eval_step], pat0[eval_step]};
    assign hit       = |hit_vec;

    always_comb begin
        first_chord = 2'd0;
        if (hit_vec[0])      first_chord = 2'd0;
        else if (hit_vec[1]) first_chord = 2'd1;
        else if (hit_vec[2]) first_chord = 2'd2;
        else if (hit_vec[3]) first_chord = 2'd3;
    end

    assign fire       = eval && !defer && hit;
    assign start_gate = fire && (gate_len != '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            period_q <= '0;
            cnt_q    <= '0;
            step_q   <= 2'd0;
            chord_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            chord_q  <= chord_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = '0;
        period_d = period_q;
        step_d   = step_q;
        chord_d  = chord_q;

        // Period is only re-sampled on a wrap so a running step never changes length.
        if (!running) begin
            div_d    = '0;
            period_d = p_new;
            step_d   = 2'd0;
            chord_d  = 2'd0;
        end else begin
            div_d = wrap ? '0 : div_q + CNT_W'(1);
            if (wrap) period_d = p_new;
            if (tick) step_d = step_q + 2'd1;
            if (fire) chord_d = first_chord;
        end

        if (!loop_en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (state_q == S_IDLE) begin
            state_d = S_START;
            cnt_d   = '0;
`ifdef LOOP_SWING_EN
        end else if (defer) begin
            state_d = S_SWING;
            cnt_d   = swing_len - CNT_W'(1);
`endif
        end else if (eval) begin
            // The evaluation cycle is the first gate cycle, so the counter holds the remainder.
            if (start_gate && (gate_len > CNT_W'(1))) begin
                state_d = S_GATE;
                cnt_d   = gate_len - CNT_W'(1);
            end else begin
                state_d = S_REST;
                cnt_d   = '0;
            end
        end else begin
            case (state_q)
                S_GATE: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = S_REST;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
`ifdef LOOP_SWING_EN
                S_SWING: cnt_d = cnt_q - CNT_W'(1);
`endif
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        shift_en  = tick;
        step      = step_q;
        track_led = (state_q == S_IDLE) ? 4'b0000 : (4'b0001 << step_q);
        chord_sel = fire ? first_chord : chord_q;
        note_trig = start_gate;
        note_gate = start_gate || ((state_q == S_GATE) && !eval);
    end

endmodule
